// File: rtl/alu_issue_ctrl.sv
// Issue/control front-end for the 32-bit combinational ALU: accepts requests,
// decodes ALUOp/funct into the ALU select code, runs one execute cycle and
// returns the captured result over a valid/ready response channel.
module alu_issue_ctrl #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               REQ_VALID,
    output logic               REQ_READY,
    input  logic [1:0]         ALU_OP,
    input  logic [5:0]         FUNCT,
    input  logic [31:0]        A,
    input  logic [31:0]        B,
    output logic [31:0]        OPERADOR1,
    output logic [31:0]        OPERADOR2,
    output logic [2:0]         SEL,
    input  logic [31:0]        RESULTADO,
    output logic               RSP_VALID,
    input  logic               RSP_READY,
    output logic [31:0]        RSP_DATA,
    output logic               RSP_ZERO,
    output logic               RSP_ILLEGAL,
    output logic [COUNT_W-1:0] OP_COUNT
);

    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    logic               req_ready_q;
    logic [31:0]        op1_q;
    logic [31:0]        op2_q;
    logic [SEL_W-1:0]   sel_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_data_q;
    logic               rsp_zero_q;
    logic               rsp_illegal_q;
    logic [COUNT_W-1:0] op_count_q;

    logic [SEL_W-1:0]   dec_sel_c;
    logic               dec_illegal_c;

    // Translate main-decoder ALUOp / R-type funct into the ALU select code.
    always_comb begin
        dec_sel_c     = 3'b000;
        dec_illegal_c = 1'b0;
        unique case (ALU_OP)
            2'b00: dec_sel_c = 3'b010;
            2'b01: dec_sel_c = 3'b110;
            2'b10: begin
                unique case (FUNCT)
                    6'b100000: dec_sel_c = 3'b010;
                    6'b100010: dec_sel_c = 3'b110;
                    6'b100100: dec_sel_c = 3'b000;
                    6'b100101: dec_sel_c = 3'b001;
                    6'b100111: dec_sel_c = 3'b100;
                    6'b101010: dec_sel_c = 3'b111;
                    default:   dec_illegal_c = 1'b1;
                endcase
            end
            default: dec_illegal_c = 1'b1;
        endcase
    end

    // Issue FSM: IDLE accepts, EXEC lets the ALU settle for one cycle, RESP holds the result.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            op1_q         <= '0;
            op2_q         <= '0;
            sel_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
            op_count_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (REQ_VALID) begin
                        req_ready_q <= 1'b0;
                        if (dec_illegal_c) begin
                            // Undecodable: answer immediately, leave ALU inputs untouched.
                            rsp_data_q    <= '0;
                            rsp_zero_q    <= 1'b1;
                            rsp_illegal_q <= 1'b1;
                            rsp_valid_q   <= 1'b1;
                            state_q       <= RESP;
                        end else begin
                            op1_q   <= A;
                            op2_q   <= B;
                            sel_q   <= dec_sel_c;
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rsp_data_q    <= RESULTADO;
                    rsp_zero_q    <= (RESULTADO == 32'd0);
                    rsp_illegal_q <= 1'b0;
                    rsp_valid_q   <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        op_count_q  <= op_count_q + COUNT_W'(1);
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign REQ_READY   = req_ready_q;
    assign OPERADOR1   = op1_q;
    assign OPERADOR2   = op2_q;
    assign SEL         = sel_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_DATA    = rsp_data_q;
    assign RSP_ZERO    = rsp_zero_q;
    assign RSP_ILLEGAL = rsp_illegal_q;
    assign OP_COUNT    = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed and random requests against an
// operation-level reference model; a second instance with a 2-bit counter
// checks OP_COUNT wrap.
module tb_alu_issue_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ_VALID;
    logic [1:0]  ALU_OP;
    logic [5:0]  FUNCT;
    logic [31:0] A, B;
    logic        RSP_READY;

    logic        REQ_READY, RSP_VALID, RSP_ZERO, RSP_ILLEGAL;
    logic [31:0] OPERADOR1, OPERADOR2, RSP_DATA, RESULTADO;
    logic [2:0]  SEL;
    logic [15:0] OP_COUNT;

    logic        REQ_READY2, RSP_VALID2, RSP_ZERO2, RSP_ILLEGAL2;
    logic [31:0] OPERADOR1_2, OPERADOR2_2, RSP_DATA2, RESULTADO2;
    logic [2:0]  SEL2;
    logic [1:0]  OP_COUNT2;

    int checks = 0;
    int errors = 0;
    int cnt = 0;
    logic [2:0]  sel_m;
    logic [31:0] op1_m, op2_m;

    always #5 CLK = ~CLK;

    // Environment: the combinational ALU the controller drives.
    function automatic logic [31:0] alu_env(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y);
        case (s)
            3'b010:  return x + y;
            3'b110:  return x - y;
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b100:  return ~(x | y);
            3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign RESULTADO  = alu_env(SEL, OPERADOR1, OPERADOR2);
    assign RESULTADO2 = alu_env(SEL2, OPERADOR1_2, OPERADOR2_2);

    alu_issue_ctrl #(.COUNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .ALU_OP(ALU_OP), .FUNCT(FUNCT), .A(A), .B(B),
        .OPERADOR1(OPERADOR1), .OPERADOR2(OPERADOR2), .SEL(SEL), .RESULTADO(RESULTADO),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .RSP_ZERO(RSP_ZERO), .RSP_ILLEGAL(RSP_ILLEGAL), .OP_COUNT(OP_COUNT)
    );

    alu_issue_ctrl #(.COUNT_W(2)) dut2 (
        .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY2),
        .ALU_OP(ALU_OP), .FUNCT(FUNCT), .A(A), .B(B),
        .OPERADOR1(OPERADOR1_2), .OPERADOR2(OPERADOR2_2), .SEL(SEL2), .RESULTADO(RESULTADO2),
        .RSP_VALID(RSP_VALID2), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA2),
        .RSP_ZERO(RSP_ZERO2), .RSP_ILLEGAL(RSP_ILLEGAL2), .OP_COUNT(OP_COUNT2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: what operation the request names, its select code and its result.
    task automatic ref_model(input logic [1:0] op, input logic [5:0] fn,
                             input logic [31:0] a, input logic [31:0] b,
                             output logic ill, output logic [2:0] sel, output logic [31:0] res);
        string name;
        name = "bad";
        if (op == 2'b00) name = "add";
        else if (op == 2'b01) name = "sub";
        else if (op == 2'b10) begin
            if (fn == 6'd32) name = "add";
            else if (fn == 6'd34) name = "sub";
            else if (fn == 6'd36) name = "and";
            else if (fn == 6'd37) name = "or";
            else if (fn == 6'd39) name = "nor";
            else if (fn == 6'd42) name = "slt";
        end
        ill = (name == "bad");
        sel = 3'b000;
        res = 32'd0;
        if (name == "add") begin sel = 3'b010; res = a + b; end
        if (name == "sub") begin sel = 3'b110; res = a - b; end
        if (name == "and") begin sel = 3'b000; res = a & b; end
        if (name == "or")  begin sel = 3'b001; res = a | b; end
        if (name == "nor") begin sel = 3'b100; res = ~(a | b); end
        if (name == "slt") begin sel = 3'b111; res = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
    endtask

    // One full transaction: request, execute, response held for 'hold' cycles, handshake.
    task automatic do_req(input logic [1:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit keep_valid);
        logic        ill;
        logic [2:0]  esel;
        logic [31:0] eres;
        int          n;
        ref_model(op, fn, a, b, ill, esel, eres);
        REQ_VALID = 1'b1; ALU_OP = op; FUNCT = fn; A = a; B = b; RSP_READY = 1'b0;
        n = 0;
        while (REQ_READY !== 1'b1 && n < 50) begin step(); n++; end
        chk("accept_wait", 32'(n < 50), 32'd1);
        step();
        if (!keep_valid) REQ_VALID = 1'b0;
        A = $urandom; B = $urandom;
        chk("req_ready_busy", 32'(REQ_READY), 32'd0);
        if (ill) begin
            chk("ill_valid_k1", 32'(RSP_VALID), 32'd1);
            chk("ill_flag", 32'(RSP_ILLEGAL), 32'd1);
            chk("ill_zero", 32'(RSP_ZERO), 32'd1);
            chk("ill_data", RSP_DATA, 32'd0);
            chk("ill_sel_kept", 32'(SEL), 32'(sel_m));
            chk("ill_op1_kept", OPERADOR1, op1_m);
        end else begin
            chk("exec_no_valid", 32'(RSP_VALID), 32'd0);
            chk("sel", 32'(SEL), 32'(esel));
            chk("op1", OPERADOR1, a);
            chk("op2", OPERADOR2, b);
            sel_m = esel; op1_m = a; op2_m = b;
            step();
            chk("valid_k2", 32'(RSP_VALID), 32'd1);
            chk("data", RSP_DATA, eres);
            chk("zero", 32'(RSP_ZERO), 32'(eres == 32'd0));
            chk("legal_flag", 32'(RSP_ILLEGAL), 32'd0);
            chk("op1_hold", OPERADOR1, a);
        end
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", 32'(RSP_VALID), 32'd1);
            chk("hold_data", RSP_DATA, ill ? 32'd0 : eres);
            chk("hold_ready", 32'(REQ_READY), 32'd0);
        end
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        REQ_VALID = 1'b0;
        cnt++;
        chk("post_hs_valid", 32'(RSP_VALID), 32'd0);
        chk("post_hs_ready", 32'(REQ_READY), 32'd1);
        chk("op_count", 32'(OP_COUNT), 32'(cnt % 65536));
        chk("op_count_w2", 32'(OP_COUNT2), 32'(cnt % 4));
        chk("sel_idle", 32'(SEL), 32'(sel_m));
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", 32'(REQ_READY), 32'd1);
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("rst_op1", OPERADOR1, 32'd0);
        chk("rst_op2", OPERADOR2, 32'd0);
        chk("rst_sel", 32'(SEL), 32'd0);
        chk("rst_data", RSP_DATA, 32'd0);
        chk("rst_zero", 32'(RSP_ZERO), 32'd0);
        chk("rst_ill", 32'(RSP_ILLEGAL), 32'd0);
        chk("rst_count", 32'(OP_COUNT), 32'd0);
        chk("rst_count_w2", 32'(OP_COUNT2), 32'd0);
        cnt = 0; sel_m = 3'b000; op1_m = 32'd0; op2_m = 32'd0;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [5:0]  rfn;
        logic [31:0] ra, rb;
        logic [5:0]  legal_fn [6];
        int          idx;
        legal_fn[0] = 6'd32; legal_fn[1] = 6'd34; legal_fn[2] = 6'd36;
        legal_fn[3] = 6'd37; legal_fn[4] = 6'd39; legal_fn[5] = 6'd42;

        RESET = 1'b1; REQ_VALID = 1'b0; ALU_OP = 2'b00; FUNCT = 6'd0;
        A = 32'd0; B = 32'd0; RSP_READY = 1'b0;
        step(); step();
        chk_reset_vals();
        RESET = 1'b0;

        // Directed operations
        do_req(2'b10, 6'd32, 32'd5, 32'd7, 0, 1'b0);
        do_req(2'b01, 6'd0, 32'd9, 32'd9, 0, 1'b0);
        do_req(2'b10, 6'd42, 32'd3, 32'd8, 1, 1'b0);
        do_req(2'b10, 6'd42, 32'd8, 32'd3, 0, 1'b0);
        do_req(2'b10, 6'd42, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        do_req(2'b10, 6'd0, 32'd1, 32'd2, 0, 1'b0);
        do_req(2'b11, 6'd32, 32'd1, 32'd2, 2, 1'b0);
        do_req(2'b10, 6'd39, 32'h0F0F_0000, 32'h0000_00F0, 5, 1'b1);

        // Random operations
        for (int t = 0; t < 40; t++) begin
            rop = 2'($urandom_range(0, 3));
            idx = $urandom_range(0, 7);
            rfn = (idx < 6) ? legal_fn[idx] : 6'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            do_req(rop, rfn, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset during EXEC drops the request
        REQ_VALID = 1'b1; ALU_OP = 2'b00; A = 32'd40; B = 32'd2;
        step();
        REQ_VALID = 1'b0;
        chk("exec_entered_sel", 32'(SEL), 32'b010);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk_reset_vals();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_rsp_after_rst", 32'(RSP_VALID), 32'd0);
        end

        // Reset wins over a simultaneous request handshake
        do_req(2'b10, 6'd37, 32'h1234_0000, 32'h0000_5678, 0, 1'b0);
        REQ_VALID = 1'b1; ALU_OP = 2'b00; A = 32'd1; B = 32'd1; RESET = 1'b1;
        step();
        RESET = 1'b0; REQ_VALID = 1'b0;
        chk_reset_vals();
        step();
        chk("rst_win_ready", 32'(REQ_READY), 32'd1);
        chk("rst_win_sel", 32'(SEL), 32'd0);

        // Counter wrap on the 2-bit instance: 5 handshakes -> 1
        for (int t = 0; t < 5; t++)
            do_req(2'b00, 6'd0, 32'($urandom), 32'($urandom), 0, 1'b0);
        chk("wrap_w2", 32'(OP_COUNT2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential issue/control front-end for the 32-bit combinational ALU. It is the side that drives the ALU's operand and select inputs and consumes its result.
- Accepts ALU requests (ALUOp/funct plus two operands) over a valid/ready handshake and decodes them into the 3-bit ALU select code.
- Drives registered operands into the ALU for one execute cycle, captures the result, and returns it over a second valid/ready handshake with zero and illegal flags.
- Sits between the datapath control (main decoder) and the ALU.

Parameters:
COUNT_W, 16, width of the completed-operation counter OP_COUNT

Ports:
CLK  input  1  system clock; all state updates on the rising edge
RESET  input  1  synchronous, active-high reset
REQ_VALID  input  1  request present
REQ_READY  output  1  block can accept a request
ALU_OP  input  2  main-decoder ALUOp: 00 add, 01 sub, 10 use FUNCT, 11 reserved
FUNCT  input  6  R-type funct field
A  input  32  first operand
B  input  32  second operand
OPERADOR1  output  32  registered operand to ALU
OPERADOR2  output  32  registered operand to ALU
SEL  output  3  registered ALU select code
RESULTADO  input  32  combinational ALU result
RSP_VALID  output  1  response present
RSP_READY  input  1  consumer accepts response
RSP_DATA  output  32  captured result
RSP_ZERO  output  1  RSP_DATA == 0
RSP_ILLEGAL  output  1  request was undecodable
OP_COUNT  output  COUNT_W  number of completed response handshakes

Behaviour:
- Reset (RESET=1 at a rising edge, regardless of state):
  - State goes to IDLE.
  - REQ_READY=1, RSP_VALID=0.
  - OPERADOR1, OPERADOR2 and RSP_DATA = 0.
  - SEL=3'b000, RSP_ZERO=0, RSP_ILLEGAL=0, OP_COUNT=0.
  - An in-flight request is dropped and no response is produced for it.
- Decode (at acceptance):
  - ALU_OP=00 -> SEL 010.
  - ALU_OP=01 -> SEL 110.
  - ALU_OP=10: FUNCT 100000 -> 010 (add), 100010 -> 110 (sub), 100100 -> 000 (and), 100101 -> 001 (or), 100111 -> 100 (nor), 101010 -> 111 (slt).
  - Any other FUNCT, or ALU_OP=11, is illegal.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: REQ_READY=1. A handshake (REQ_VALID & REQ_READY) latches A into OPERADOR1, B into OPERADOR2, and the decoded code into SEL.
    - Legal request -> EXEC.
    - Illegal request -> RESP, with RSP_DATA=0, RSP_ILLEGAL=1, RSP_ZERO=1. Operand and SEL registers are left unchanged.
  - EXEC: REQ_READY=0, for exactly one cycle. At the next edge RESULTADO is captured into RSP_DATA, RSP_ZERO=(RESULTADO==0), RSP_ILLEGAL=0 -> RESP.
  - RESP: RSP_VALID=1 and REQ_READY=0. RSP_DATA and the flags are held stable until RSP_READY=1 at an edge.
    - On that edge: go to IDLE, RSP_VALID deasserts, OP_COUNT increments.
- Latency and throughput:
  - Legal request accepted at edge k -> RSP_VALID=1 from edge k+2.
  - Illegal request -> RSP_VALID=1 from edge k+1.
  - Maximum throughput is one operation per 3 cycles with RSP_READY held high.
- OPERADOR1, OPERADOR2 and SEL keep their last values outside EXEC (no toggling when idle).
- OP_COUNT counts illegal responses too, and wraps modulo 2^COUNT_W.
- REQ_VALID while not in IDLE: ignored, no handshake; the requester must hold it.
- RSP_READY in IDLE or EXEC: no effect.
- RESET asserted in the same cycle as any handshake: reset wins.

Test Plan:
- Reset, then ALU_OP=10, FUNCT=100000, A=5, B=7 -> SEL=010; RSP_VALID at edge k+2 with RSP_DATA=12, RSP_ZERO=0; OP_COUNT=1 after handshake.
- ALU_OP=01, A=9, B=9 -> SEL=110, RSP_DATA=0, RSP_ZERO=1.
- ALU_OP=10, FUNCT=101010, A=3, B=8 then A=8, B=3 -> RSP_DATA 1 then 0. Second request is not accepted until the first response handshakes.
- ALU_OP=10, FUNCT=000000 and ALU_OP=11 -> RSP_VALID at k+1, RSP_ILLEGAL=1, RSP_DATA=0; SEL keeps its prior value.
- Hold RSP_READY=0 for 5 cycles during RESP while REQ_VALID stays 1 -> RSP_DATA stable, REQ_READY=0; then RSP_READY=1 -> one handshake and IDLE next cycle.
- Assert RESET during EXEC -> next cycle all outputs at reset values, no response issued. Separately, with COUNT_W=2, do 5 handshakes -> OP_COUNT=1.
